// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN result transmitter: FSM states and ASCII codes.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_SEND_D,
    S_WAIT_D,
    S_SEND_NL,
    S_WAIT_NL,
    S_DONE
  } res_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Class 0..9 maps to '0'..'9', 10..15 maps to 'A'..'F'.
  function automatic logic [7:0] class_to_ascii(input logic [3:0] c);
    if (c <= 4'd9) return ASCII_0 + {4'd0, c};
    else           return ASCII_A + {4'd0, c} - 8'd10;
  endfunction

endpackage

// File: rtl/cnn_argmax.sv
// Running max/index tracker over one frame of signed scores; ties keep the lower index.
module cnn_argmax
  import cnn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  localparam int CNT_W      = $clog2(NUM_CLASSES) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      vld,
  input  logic signed [SCORE_W-1:0] score,
  output logic signed [SCORE_W-1:0] max,
  output logic [3:0]                arg,
  output logic                      last
);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [SCORE_W-1:0] max_q, max_d;
  logic [3:0]                arg_q, arg_d;

  assign last = vld && (cnt_q == CNT_W'(NUM_CLASSES - 1));
  assign max  = max_q;
  assign arg  = arg_q;

  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    arg_d = arg_q;
    if (clr) begin
      cnt_d = '0;
    end else if (vld) begin
      // The first score of a frame seeds the running max unconditionally.
      if (cnt_q == '0) begin
        max_d = score;
        arg_d = 4'd0;
      end else if (score > max_q) begin
        max_d = score;
        arg_d = 4'(cnt_q);
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      max_q <= '0;
      arg_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      arg_q <= arg_d;
    end
  end

endmodule

// File: rtl/cnn_result_tx.sv
// Collects one frame of class scores, picks the argmax, shows it on LEDs and sends it as ASCII.
module cnn_result_tx
  import cnn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter bit SEND_NL     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      score_vld,
  input  logic signed [SCORE_W-1:0] score,
  input  logic                      tx_done,
  output logic                      trmt,
  output logic [7:0]                tx_data,
  output logic                      bsy,
  output logic                      frame_done,
  output logic                      overrun,
  output logic [7:0]                LED
);

  res_state_t                state_q, state_d;
  logic [7:0]                led_q, led_d;
  logic                      overrun_q, overrun_d;
  logic                      acc_vld, last, clr;
  logic signed [SCORE_W-1:0] max_val;
  logic [3:0]                arg;
  logic [7:0]                digit;

  assign acc_vld = score_vld && (state_q == S_IDLE || state_q == S_ACC);
  assign clr     = (state_q == S_DONE);
  assign digit   = class_to_ascii(arg);
  assign LED     = led_q;
  assign overrun = overrun_q;

  cnn_argmax #(
    .NUM_CLASSES(NUM_CLASSES),
    .SCORE_W    (SCORE_W)
  ) u_argmax (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .vld  (acc_vld),
    .score(score),
    .max  (max_val),
    .arg  (arg),
    .last (last)
  );

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    overrun_d  = overrun_q;
    trmt       = 1'b0;
    tx_data    = 8'h00;
    bsy        = 1'b0;
    frame_done = 1'b0;
    // Scores arriving while a result is being reported are dropped and flagged.
    if (score_vld && !(state_q == S_IDLE || state_q == S_ACC)) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (acc_vld) state_d = S_ACC;
      end
      S_ACC: begin
        bsy = 1'b1;
        if (last) state_d = S_SEND_D;
      end
      S_SEND_D: begin
        bsy     = 1'b1;
        trmt    = 1'b1;
        tx_data = digit;
        led_d   = {1'b1, 3'b000, arg};
        state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        bsy     = 1'b1;
        tx_data = digit;
        if (tx_done) state_d = SEND_NL ? S_SEND_NL : S_DONE;
      end
      S_SEND_NL: begin
        bsy     = 1'b1;
        trmt    = 1'b1;
        tx_data = ASCII_LF;
        state_d = S_WAIT_NL;
      end
      S_WAIT_NL: begin
        bsy     = 1'b1;
        tx_data = ASCII_LF;
        if (tx_done) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      led_q     <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
